// File: rtl/gen_cnt_pkg.sv
// Shared types and next-count arithmetic for the gen_cnt counter family.
// The arithmetic runs one bit wider than the largest supported count width.
package gen_cnt_pkg;

    typedef enum logic [0:0] {CNT_MODE_WRAP, CNT_MODE_SAT} cnt_mode_t;

    localparam int CNT_W_DEFAULT = 4;
    localparam int CNT_W_MAX     = 32;

    typedef logic [CNT_W_MAX:0] cnt_wide_t;

    typedef struct packed {
        cnt_wide_t cnt;
        logic      ovf;
        logic      unf;
    } cnt_res_t;

    function automatic cnt_res_t cnt_next(
        input cnt_wide_t count,
        input cnt_wide_t step,
        input cnt_wide_t lim,
        input cnt_mode_t mode,
        input logic      up
    );
        cnt_res_t  res;
        cnt_wide_t span;
        cnt_wide_t sum;
        res.cnt = count;
        res.ovf = 1'b0;
        res.unf = 1'b0;
        span    = lim + cnt_wide_t'(1);
        sum     = count + step;
        if (step != '0) begin
            if (up) begin
                // A count stranded above a lowered limit always counts as an overflow.
                if (count > lim) begin
                    res.cnt = (mode == CNT_MODE_SAT) ? lim : '0;
                    res.ovf = 1'b1;
                end else if (sum > lim) begin
                    if (mode == CNT_MODE_SAT) begin
                        res.cnt = lim;
                        res.ovf = (count != lim);
                    end else begin
                        res.cnt = sum - span;
                        res.ovf = 1'b1;
                    end
                end else begin
                    res.cnt = sum;
                end
            end else begin
                if (count >= step) begin
                    res.cnt = count - step;
                end else if (mode == CNT_MODE_SAT) begin
                    res.cnt = '0;
                    res.unf = (count != '0);
                end else begin
                    res.cnt = count + span - step;
                    res.unf = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/gen_cnt_ch.sv
// One counter channel: clear/load/step priority, registered count and event pulses.
// GEN_CNT_MC_STICKY_EN adds sticky overflow/underflow flags.
module gen_cnt_ch
    import gen_cnt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  cnt_mode_t        mode,
    input  logic [CNT_W-1:0] lim,
    input  logic [CNT_W-1:0] step,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
`ifdef GEN_CNT_MC_STICKY_EN
    input  logic             sticky_clr,
    output logic             ovf_stky,
    output logic             unf_stky,
`endif
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic             unf,
    output logic             at_lim,
    output logic             at_zero
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    cnt_res_t         res;

    assign res = cnt_next(cnt_wide_t'(count_q), cnt_wide_t'(step), cnt_wide_t'(lim), mode, inc);

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (ld) begin
            count_d = (ld_val > lim) ? lim : ld_val;
        end else if (inc ^ dec) begin
            // Only an illegal step can push the result past the count width; pin it to lim.
            count_d = (|res.cnt[CNT_W_MAX:CNT_W]) ? lim : res.cnt[CNT_W-1:0];
            ovf_d   = res.ovf;
            unf_d   = res.unf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef GEN_CNT_MC_STICKY_EN
    logic ovf_stky_q, ovf_stky_d;
    logic unf_stky_q, unf_stky_d;

    always_comb begin
        ovf_stky_d = ovf_d | (ovf_stky_q & ~sticky_clr);
        unf_stky_d = unf_d | (unf_stky_q & ~sticky_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_stky_q <= 1'b0;
            unf_stky_q <= 1'b0;
        end else begin
            ovf_stky_q <= ovf_stky_d;
            unf_stky_q <= unf_stky_d;
        end
    end

    assign ovf_stky = ovf_stky_q;
    assign unf_stky = unf_stky_q;
`endif

    assign count   = count_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;
    assign at_lim  = (count_q == lim);
    assign at_zero = (count_q == '0);

endmodule

// File: rtl/gen_cnt_mc.sv
// Multi-channel up/down counter bank sharing one limit/step/mode configuration.
// GEN_CNT_MC_STICKY_EN adds sticky_clr, ovf_stky and unf_stky.
module gen_cnt_mc
    import gen_cnt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int NCH   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [CNT_W-1:0]     lim,
    input  logic [CNT_W-1:0]     step,
    input  logic [NCH-1:0]       inc,
    input  logic [NCH-1:0]       dec,
    input  logic [NCH-1:0]       clr,
    input  logic [NCH-1:0]       ld,
    input  logic [NCH*CNT_W-1:0] ld_val,
`ifdef GEN_CNT_MC_STICKY_EN
    input  logic [NCH-1:0]       sticky_clr,
    output logic [NCH-1:0]       ovf_stky,
    output logic [NCH-1:0]       unf_stky,
`endif
    output logic [NCH*CNT_W-1:0] count,
    output logic [NCH-1:0]       ovf,
    output logic [NCH-1:0]       unf,
    output logic [NCH-1:0]       at_lim,
    output logic [NCH-1:0]       at_zero
);

    cnt_mode_t mode_e;

    assign mode_e = cnt_mode_t'(mode);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        gen_cnt_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .mode       (mode_e),
            .lim        (lim),
            .step       (step),
            .inc        (inc[i]),
            .dec        (dec[i]),
            .clr        (clr[i]),
            .ld         (ld[i]),
            .ld_val     (ld_val[i*CNT_W +: CNT_W]),
`ifdef GEN_CNT_MC_STICKY_EN
            .sticky_clr (sticky_clr[i]),
            .ovf_stky   (ovf_stky[i]),
            .unf_stky   (unf_stky[i]),
`endif
            .count      (count[i*CNT_W +: CNT_W]),
            .ovf        (ovf[i]),
            .unf        (unf[i]),
            .at_lim     (at_lim[i]),
            .at_zero    (at_zero[i])
        );
    end

endmodule

// File: tb/tb_gen_cnt_mc.sv
// Directed bench for gen_cnt_mc (CNT_W=4, NCH=2); covers the sticky flags when
// GEN_CNT_MC_STICKY_EN is defined.
module tb_gen_cnt_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [3:0] lim;
    logic [3:0] step;
    logic [1:0] inc, dec, clr, ld;
    logic [7:0] ld_val;
    logic [7:0] count;
    logic [1:0] ovf, unf, at_lim, at_zero;
`ifdef GEN_CNT_MC_STICKY_EN
    logic [1:0] sticky_clr;
    logic [1:0] ovf_stky, unf_stky;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gen_cnt_mc #(
        .CNT_W (4),
        .NCH   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .lim        (lim),
        .step       (step),
        .inc        (inc),
        .dec        (dec),
        .clr        (clr),
        .ld         (ld),
        .ld_val     (ld_val),
`ifdef GEN_CNT_MC_STICKY_EN
        .sticky_clr (sticky_clr),
        .ovf_stky   (ovf_stky),
        .unf_stky   (unf_stky),
`endif
        .count      (count),
        .ovf        (ovf),
        .unf        (unf),
        .at_lim     (at_lim),
        .at_zero    (at_zero)
    );

    // Drive the per-channel requests, then let one clock edge act on them.
    task automatic applyStimulus(input logic [1:0] i_inc, input logic [1:0] i_dec,
                                 input logic [1:0] i_clr, input logic [1:0] i_ld,
                                 input logic [7:0] i_ldv);
        inc    = i_inc;
        dec    = i_dec;
        clr    = i_clr;
        ld     = i_ld;
        ld_val = i_ldv;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic [7:0] e_cnt,
                              input logic [1:0] e_ovf, input logic [1:0] e_unf);
        checkOutput({tag, ".count"}, 32'(count), 32'(e_cnt));
        checkOutput({tag, ".ovf"},   32'(ovf),   32'(e_ovf));
        checkOutput({tag, ".unf"},   32'(unf),   32'(e_unf));
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = 1'b0;
        lim   = 4'd9;
        step  = 4'd1;
        inc = '0; dec = '0; clr = '0; ld = '0; ld_val = '0;
`ifdef GEN_CNT_MC_STICKY_EN
        sticky_clr = '0;
`endif

        // Reset dominates a pending increment.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 8'h00);
            checkState("reset", 8'h00, 2'b00, 2'b00);
        end
        checkOutput("reset.at_zero", 32'(at_zero), 32'h3);
        rst_n = 1'b1;
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 8'h00);
        checkState("release", 8'h01, 2'b00, 2'b00);
        applyStimulus(2'b00, 2'b00, 2'b01, 2'b00, 8'h00);
        checkState("clr", 8'h00, 2'b00, 2'b00);

        // Wrap mode, step 3, lim 9: 3, 6, 9, 2(ovf), then dec 2 -> 9(unf).
        step = 4'd3;
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 8'h00);
        checkState("wrap.s1", 8'h03, 2'b00, 2'b00);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 8'h00);
        checkState("wrap.s2", 8'h06, 2'b00, 2'b00);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 8'h00);
        checkState("wrap.s3", 8'h09, 2'b00, 2'b00);
        checkOutput("wrap.at_lim", 32'(at_lim), 32'h1);
        checkOutput("wrap.at_zero", 32'(at_zero), 32'h2);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 8'h00);
        checkState("wrap.s4", 8'h02, 2'b01, 2'b00);
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00, 8'h00);
        checkState("wrap.dec", 8'h09, 2'b00, 2'b01);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 8'h00);
        checkState("wrap.idle", 8'h09, 2'b00, 2'b00);

        step = 4'd0;
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 8'h00);
        checkState("step0", 8'h09, 2'b00, 2'b00);

        // Saturate mode, lim 12, step 5.
        mode = 1'b1;
        lim  = 4'd12;
        step = 4'd5;
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, 8'h0A);
        checkState("sat.ld", 8'h0A, 2'b00, 2'b00);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 8'h00);
        checkState("sat.clamp", 8'h0C, 2'b01, 2'b00);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 8'h00);
        checkState("sat.atlim", 8'h0C, 2'b00, 2'b00);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, 8'h03);
        checkState("sat.ld3", 8'h03, 2'b00, 2'b00);
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00, 8'h00);
        checkState("sat.floor", 8'h00, 2'b00, 2'b01);
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00, 8'h00);
        checkState("sat.atzero", 8'h00, 2'b00, 2'b00);

        // Priority: clr > ld > (inc & dec hold) > inc/dec.
        mode = 1'b0;
        lim  = 4'd9;
        step = 4'd1;
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, 8'h04);
        checkState("prio.ld4", 8'h04, 2'b00, 2'b00);
        applyStimulus(2'b01, 2'b00, 2'b01, 2'b01, 8'h07);
        checkState("prio.clr", 8'h00, 2'b00, 2'b00);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b01, 8'h07);
        checkState("prio.ld", 8'h07, 2'b00, 2'b00);
        applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 8'h00);
        checkState("prio.hold", 8'h07, 2'b00, 2'b00);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, 8'h0F);
        checkState("prio.ldclamp", 8'h09, 2'b00, 2'b00);

        // Channel independence.
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b11, 8'h55);
        checkState("ind.ld", 8'h55, 2'b00, 2'b00);
        applyStimulus(2'b01, 2'b10, 2'b00, 2'b00, 8'h00);
        checkState("ind.step", 8'h46, 2'b00, 2'b00);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b11, 8'h09);
        checkState("ind.ld2", 8'h09, 2'b00, 2'b00);
        applyStimulus(2'b01, 2'b10, 2'b00, 2'b00, 8'h00);
        checkState("ind.edges", 8'h90, 2'b01, 2'b10);

        // Full-range modulo counter.
        lim = 4'd15;
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, 8'h0F);
        checkState("mod.ld", 8'h9F, 2'b00, 2'b00);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 8'h00);
        checkState("mod.wrap", 8'h90, 2'b01, 2'b00);

        // Limit lowered under live counts.
        lim = 4'd9;
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, 8'h08);
        checkState("rt.ld", 8'h98, 2'b00, 2'b00);
        lim = 4'd5;
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 8'h00);
        checkState("rt.wrapinc", 8'h90, 2'b01, 2'b00);
`ifdef GEN_CNT_MC_STICKY_EN
        checkOutput("stky.ovf_set", 32'(ovf_stky), 32'h1);
        checkOutput("stky.unf_set", 32'(unf_stky), 32'h2);
`endif
        applyStimulus(2'b00, 2'b10, 2'b00, 2'b00, 8'h00);
        checkState("rt.dec", 8'h80, 2'b00, 2'b00);
`ifdef GEN_CNT_MC_STICKY_EN
        checkOutput("stky.hold", 32'(ovf_stky), 32'h1);
`endif
        mode = 1'b1;
        applyStimulus(2'b10, 2'b00, 2'b00, 2'b00, 8'h00);
        checkState("rt.satinc", 8'h50, 2'b10, 2'b00);
        checkOutput("rt.at_lim", 32'(at_lim), 32'h2);
        checkOutput("rt.at_zero", 32'(at_zero), 32'h1);

        mode = 1'b0;
`ifdef GEN_CNT_MC_STICKY_EN
        sticky_clr = 2'b11;
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 8'h00);
        checkOutput("stky.clr_ovf", 32'(ovf_stky), 32'h0);
        checkOutput("stky.clr_unf", 32'(unf_stky), 32'h0);
        sticky_clr = 2'b01;
`endif
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00, 8'h00);
        checkState("rt.decwrap", 8'h55, 2'b00, 2'b01);
`ifdef GEN_CNT_MC_STICKY_EN
        checkOutput("stky.setwins", 32'(unf_stky), 32'h1);
        sticky_clr = 2'b00;
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 8'h00);
        checkOutput("stky.keep", 32'(unf_stky), 32'h1);
`endif

        // Reset mid-operation.
        rst_n = 1'b0;
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 8'h00);
        checkState("midreset", 8'h00, 2'b00, 2'b00);
`ifdef GEN_CNT_MC_STICKY_EN
        checkOutput("midreset.stky", 32'({ovf_stky, unf_stky}), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
